// File: rtl/seq_pkg.sv
// Shared types, defaults and helpers for the run-length pattern scheduler.
package seq_pkg;

    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned FRM_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Next high-run length: grow by step, fall back to the start length past the limit.
    // Operands are zero-extended run-length fields, so the sum cannot overflow.
    function automatic int unsigned next_len(input int unsigned cur,
                                             input int unsigned step,
                                             input int unsigned start_len,
                                             input int unsigned limit);
        int unsigned nxt;
        nxt = cur + step;
        return (nxt > limit) ? start_len : nxt;
    endfunction

endpackage

// File: rtl/seq_run_cnt.sv
// Run-length down-counter with load, count enable and a registered last-cycle flag.
module seq_run_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         last_o
);

    logic [W-1:0] cnt_q;
    logic         last_q;

    // Load has priority; counting stops once the last cycle of the run is reached.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else if (load_i) begin
            cnt_q  <= load_val_i;
            last_q <= (load_val_i == '0);
        end else if (en_i && !last_q) begin
            cnt_q  <= cnt_q - W'(1);
            last_q <= (cnt_q == W'(1));
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/seq_sched.sv
// Run-length pattern scheduler: alternating high/low runs with growing, wrapping high length.
module seq_sched
    import seq_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned FRM_W = FRM_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [CNT_W-1:0] i_cfg_hi_init,
    input  logic [CNT_W-1:0] i_cfg_hi_step,
    input  logic [CNT_W-1:0] i_cfg_hi_max,
    input  logic [CNT_W-1:0] i_cfg_lo_len,
    input  logic [FRM_W-1:0] i_cfg_frames,
    input  logic             i_hold,
    input  logic             i_stop,
    output logic             o_seq,
    output logic             o_seq_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic [FRM_W-1:0] o_frame_cnt
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hi_init_q, hi_init_d;   // effective start length (never 0)
    logic [CNT_W-1:0] hi_step_q, hi_step_d;
    logic [CNT_W-1:0] hi_max_q, hi_max_d;     // effective limit, at least the start length
    logic [CNT_W-1:0] lo_len_q, lo_len_d;     // effective low length (never 0)
    logic [FRM_W-1:0] frames_q, frames_d;
    logic [CNT_W-1:0] hi_len_q, hi_len_d;
    logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             seq_q, seq_d;
    logic             seq_valid_q, seq_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             run_load;
    logic [CNT_W-1:0] run_val;
    logic             run_en;
    logic             run_last;
    logic [CNT_W-1:0] init_in;
    logic [CNT_W-1:0] lo_in;
    logic [FRM_W-1:0] frame_inc;

    seq_run_cnt #(.W(CNT_W)) u_run_cnt (
        .clk_i      (i_clk),
        .rst_ni     (i_resetn),
        .load_i     (run_load),
        .load_val_i (run_val),
        .en_i       (run_en),
        .last_o     (run_last)
    );

    // Next-state, run-counter control and next output values.
    always_comb begin
        state_d     = state_q;
        hi_init_d   = hi_init_q;
        hi_step_d   = hi_step_q;
        hi_max_d    = hi_max_q;
        lo_len_d    = lo_len_q;
        frames_d    = frames_q;
        hi_len_d    = hi_len_q;
        frame_cnt_d = frame_cnt_q;
        cfg_ready_d = 1'b0;
        seq_d       = 1'b0;
        seq_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        run_load    = 1'b0;
        run_val     = '0;
        run_en      = 1'b0;
        init_in     = (i_cfg_hi_init == '0) ? CNT_W'(1) : i_cfg_hi_init;
        lo_in       = (i_cfg_lo_len == '0) ? CNT_W'(1) : i_cfg_lo_len;
        frame_inc   = frame_cnt_q + FRM_W'(1);

        case (state_q)
            ST_IDLE: begin
                cfg_ready_d = 1'b1;
                if (i_cfg_valid && cfg_ready_q && !i_stop) begin
                    hi_init_d   = init_in;
                    hi_step_d   = i_cfg_hi_step;
                    hi_max_d    = (i_cfg_hi_max > i_cfg_hi_init) ? i_cfg_hi_max : i_cfg_hi_init;
                    lo_len_d    = lo_in;
                    frames_d    = i_cfg_frames;
                    hi_len_d    = init_in;
                    frame_cnt_d = '0;
                    run_load    = 1'b1;
                    run_val     = init_in - CNT_W'(1);
                    state_d     = ST_HIGH;
                    cfg_ready_d = 1'b0;
                    seq_d       = 1'b1;
                    seq_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            ST_HIGH: begin
                if (i_stop) begin
                    state_d     = ST_IDLE;
                    cfg_ready_d = 1'b1;
                end else if (i_hold) begin
                    seq_d  = seq_q;
                    busy_d = 1'b1;
                end else if (run_last) begin
                    run_load    = 1'b1;
                    run_val     = lo_len_q - CNT_W'(1);
                    state_d     = ST_LOW;
                    seq_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end else begin
                    run_en      = 1'b1;
                    seq_d       = 1'b1;
                    seq_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            ST_LOW: begin
                if (i_stop) begin
                    state_d     = ST_IDLE;
                    cfg_ready_d = 1'b1;
                end else if (i_hold) begin
                    seq_d  = seq_q;
                    busy_d = 1'b1;
                end else if (run_last) begin
                    frame_cnt_d = frame_inc;
                    if ((frames_q != '0) && (frame_inc == frames_q)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        hi_len_d    = CNT_W'(next_len(32'(hi_len_q), 32'(hi_step_q),
                                                      32'(hi_init_q), 32'(hi_max_q)));
                        run_load    = 1'b1;
                        run_val     = hi_len_d - CNT_W'(1);
                        state_d     = ST_HIGH;
                        seq_d       = 1'b1;
                        seq_valid_d = 1'b1;
                        busy_d      = 1'b1;
                    end
                end else begin
                    run_en      = 1'b1;
                    seq_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                cfg_ready_d = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                cfg_ready_d = 1'b1;
            end
        endcase
    end

    // State, captured configuration and registered outputs.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q     <= ST_IDLE;
            hi_init_q   <= '0;
            hi_step_q   <= '0;
            hi_max_q    <= '0;
            lo_len_q    <= '0;
            frames_q    <= '0;
            hi_len_q    <= '0;
            frame_cnt_q <= '0;
            cfg_ready_q <= 1'b1;
            seq_q       <= 1'b0;
            seq_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_init_q   <= hi_init_d;
            hi_step_q   <= hi_step_d;
            hi_max_q    <= hi_max_d;
            lo_len_q    <= lo_len_d;
            frames_q    <= frames_d;
            hi_len_q    <= hi_len_d;
            frame_cnt_q <= frame_cnt_d;
            cfg_ready_q <= cfg_ready_d;
            seq_q       <= seq_d;
            seq_valid_q <= seq_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign o_cfg_ready = cfg_ready_q;
    assign o_seq       = seq_q;
    assign o_seq_valid = seq_valid_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_seq_sched.sv
// Directed self-checking bench for seq_sched.
module tb_seq_sched;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned FRM_W = 8;

    logic             clk;
    logic             rst_n;
    logic             i_cfg_valid;
    logic             o_cfg_ready;
    logic [CNT_W-1:0] i_cfg_hi_init;
    logic [CNT_W-1:0] i_cfg_hi_step;
    logic [CNT_W-1:0] i_cfg_hi_max;
    logic [CNT_W-1:0] i_cfg_lo_len;
    logic [FRM_W-1:0] i_cfg_frames;
    logic             i_hold;
    logic             i_stop;
    logic             o_seq;
    logic             o_seq_valid;
    logic             o_busy;
    logic             o_done;
    logic [FRM_W-1:0] o_frame_cnt;

    int n_checks = 0;
    int n_errs   = 0;
    int done_seen = 0;
    bit bits[$];

    bit exp_basic[$] = '{1,0,1,1,0,1,1,1,0,1,0};
    bit exp_zero[$]  = '{1,0,1,0,1,0};
    bit exp_one[$]   = '{1,0};
    bit exp_free[$]  = '{1,1,0,1,1,1,1,1,0,1,1,0,1,1,1,1,1,0};

    seq_sched #(.CNT_W(CNT_W), .FRM_W(FRM_W)) dut (
        .i_clk         (clk),
        .i_resetn      (rst_n),
        .i_cfg_valid   (i_cfg_valid),
        .o_cfg_ready   (o_cfg_ready),
        .i_cfg_hi_init (i_cfg_hi_init),
        .i_cfg_hi_step (i_cfg_hi_step),
        .i_cfg_hi_max  (i_cfg_hi_max),
        .i_cfg_lo_len  (i_cfg_lo_len),
        .i_cfg_frames  (i_cfg_frames),
        .i_hold        (i_hold),
        .i_stop        (i_stop),
        .o_seq         (o_seq),
        .o_seq_valid   (o_seq_valid),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_frame_cnt   (o_frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one clock and record the live pattern bit and any done pulse.
    task automatic step_rec();
        @(posedge clk);
        #1;
        if (o_seq_valid === 1'b1) bits.push_back(o_seq);
        if (o_done === 1'b1) done_seen++;
    endtask

    task automatic do_cfg(input logic [7:0] init, input logic [7:0] step, input logic [7:0] mx,
                          input logic [7:0] lo, input logic [7:0] fr);
        i_cfg_hi_init = init;
        i_cfg_hi_step = step;
        i_cfg_hi_max  = mx;
        i_cfg_lo_len  = lo;
        i_cfg_frames  = fr;
        i_cfg_valid   = 1'b1;
        bits.delete();
        done_seen = 0;
        step_rec();
        i_cfg_valid = 1'b0;
    endtask

    task automatic cmp_stream(input string tag, input bit exp[$]);
        check({tag, "_len"}, bits.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            check($sformatf("%s_bit%0d", tag, i),
                  (i < bits.size()) ? 32'(bits[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
    endtask

    initial begin
        int k;
        clk = 1'b0; rst_n = 1'b0;
        i_cfg_valid = 1'b0; i_hold = 1'b0; i_stop = 1'b0;
        i_cfg_hi_init = '0; i_cfg_hi_step = '0; i_cfg_hi_max = '0;
        i_cfg_lo_len = '0; i_cfg_frames = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_cfg_ready", o_cfg_ready, 1);
        check("rst_seq", o_seq, 0);
        check("rst_valid", o_seq_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_frame", o_frame_cnt, 0);
        @(negedge clk) rst_n = 1'b1;
        step_rec();
        check("idle_cfg_ready", o_cfg_ready, 1);

        // 1. Basic growing/wrapping runs
        do_cfg(8'd1, 8'd1, 8'd3, 8'd1, 8'd4);
        check("t1_first_seq", o_seq, 1);
        check("t1_first_busy", o_busy, 1);
        repeat (10) step_rec();
        check("t1_nvalid", bits.size(), 11);
        step_rec();
        check("t1_done", o_done, 1);
        check("t1_frame", o_frame_cnt, 4);
        check("t1_done_valid", o_seq_valid, 0);
        check("t1_done_busy", o_busy, 0);
        step_rec();
        check("t1_ready_after", o_cfg_ready, 1);
        check("t1_frame_held", o_frame_cnt, 4);
        check("t1_done_once", done_seen, 1);
        cmp_stream("t1", exp_basic);

        // 2. Zero lengths treated as 1
        do_cfg(8'd0, 8'd0, 8'd0, 8'd0, 8'd3);
        repeat (5) step_rec();
        step_rec();
        check("t2_done", o_done, 1);
        check("t2_ready_in_done", o_cfg_ready, 0);
        step_rec();
        check("t2_ready_after", o_cfg_ready, 1);
        cmp_stream("t2", exp_zero);

        // 3. Hold across the 2nd high run
        do_cfg(8'd1, 8'd1, 8'd3, 8'd1, 8'd4);
        step_rec();
        step_rec();
        check("t3_hi2_seq", o_seq, 1);
        i_hold = 1'b1;
        for (int h = 0; h < 3; h++) begin
            step_rec();
            check("t3_hold_valid", o_seq_valid, 0);
            check("t3_hold_seq", o_seq, 1);
            check("t3_hold_busy", o_busy, 1);
        end
        i_hold = 1'b0;
        repeat (8) step_rec();
        step_rec();
        check("t3_done", o_done, 1);
        check("t3_frame", o_frame_cnt, 4);
        cmp_stream("t3", exp_basic);
        step_rec();

        // 4. Stop during frame 2 LOW (with hold also high), then immediate re-config
        do_cfg(8'd1, 8'd1, 8'd3, 8'd1, 8'd4);
        repeat (4) step_rec();
        check("t4_in_low_seq", o_seq, 0);
        check("t4_in_low_valid", o_seq_valid, 1);
        i_stop = 1'b1;
        i_hold = 1'b1;
        step_rec();
        i_stop = 1'b0;
        i_hold = 1'b0;
        check("t4_stop_busy", o_busy, 0);
        check("t4_stop_seq", o_seq, 0);
        check("t4_stop_valid", o_seq_valid, 0);
        check("t4_stop_ready", o_cfg_ready, 1);
        check("t4_stop_done", o_done, 0);
        check("t4_no_done", done_seen, 0);
        do_cfg(8'd1, 8'd0, 8'd1, 8'd1, 8'd1);
        check("t4_reacc_seq", o_seq, 1);
        check("t4_reacc_busy", o_busy, 1);
        step_rec();
        step_rec();
        check("t4_re_done", o_done, 1);
        check("t4_re_frame", o_frame_cnt, 1);
        cmp_stream("t4", exp_one);
        step_rec();

        // Stop in IDLE blocks a simultaneous config
        i_cfg_valid = 1'b1;
        i_stop = 1'b1;
        step_rec();
        i_cfg_valid = 1'b0;
        i_stop = 1'b0;
        check("t4_block_busy", o_busy, 0);
        check("t4_block_ready", o_cfg_ready, 1);

        // 5. Free-running with length wrap and frame counter wrap
        do_cfg(8'd2, 8'd3, 8'd6, 8'd1, 8'd0);
        repeat (17) step_rec();
        cmp_stream("t5", exp_free);
        k = 0;
        while (o_frame_cnt !== 8'd255 && k < 3000) begin
            step_rec();
            k++;
        end
        check("t5_reach255", o_frame_cnt, 255);
        k = 0;
        while (o_frame_cnt === 8'd255 && k < 20) begin
            step_rec();
            k++;
        end
        check("t5_wrap0", o_frame_cnt, 0);
        check("t5_no_done", done_seen, 0);
        check("t5_busy", o_busy, 1);

        // 6. Async reset in the middle of a high run
        k = 0;
        while (!(o_seq === 1'b1 && o_seq_valid === 1'b1) && k < 20) begin
            step_rec();
            k++;
        end
        check("t6_in_high", o_seq, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_ready", o_cfg_ready, 1);
        check("t6_rst_seq", o_seq, 0);
        check("t6_rst_valid", o_seq_valid, 0);
        check("t6_rst_busy", o_busy, 0);
        check("t6_rst_done", o_done, 0);
        check("t6_rst_frame", o_frame_cnt, 0);
        @(negedge clk) rst_n = 1'b1;
        step_rec();
        check("t6_ready_after", o_cfg_ready, 1);
        check("t6_busy_after", o_busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_sched.md
Name: seq_sched

Overview:
Run-length pattern scheduler. It accepts a configuration through a valid/ready handshake, then emits a serial pattern of alternating high and low runs. Each high run is longer than the previous one by a programmable step, and the length wraps back at a programmable maximum. It sits in front of serial test-pattern consumers and replaces fixed, free-running sequence generators with a startable, stoppable, counted sequence.

Parameters:
CNT_W, 8, width of the run-length fields and internal run counters
FRM_W, 8, width of the frame count field and the frame counter

Ports:
i_clk  in  1  clock
i_resetn  in  1  asynchronous active-low reset
i_cfg_valid  in  1  configuration valid
o_cfg_ready  out  1  ready to accept a configuration (high only in IDLE)
i_cfg_hi_init  in  CNT_W  first high-run length; 0 is treated as 1
i_cfg_hi_step  in  CNT_W  high-run increment per frame; 0 gives a constant length
i_cfg_hi_max  in  CNT_W  largest allowed high-run length
i_cfg_lo_len  in  CNT_W  low-run length; 0 is treated as 1
i_cfg_frames  in  FRM_W  number of high+low frames; 0 means free-running
i_hold  in  1  freeze the sequence
i_stop  in  1  abort the sequence
o_seq  out  1  serial pattern bit
o_seq_valid  out  1  o_seq is a live pattern bit this cycle
o_busy  out  1  a sequence is in progress
o_done  out  1  one-cycle pulse on normal completion
o_frame_cnt  out  FRM_W  frames completed in the current sequence

Behaviour:
- All outputs are registered.
- Reset values: o_cfg_ready=1, all other outputs 0, state IDLE.
- States: IDLE, HIGH, LOW, DONE.
- IDLE:
  - o_cfg_ready=1, o_seq=0, o_seq_valid=0, o_busy=0.
  - On i_cfg_valid & o_cfg_ready: capture all i_cfg_* fields, set hi_len=max(hi_init,1), clear o_frame_cnt, go to HIGH.
  - Latency: the first o_seq=1 appears exactly 1 cycle after the accept edge.
- HIGH: o_seq=1, o_seq_valid=1, o_busy=1 for hi_len cycles, then LOW.
- LOW: o_seq=0, o_seq_valid=1 for max(lo_len,1) cycles. On the last LOW cycle:
  - o_frame_cnt increments.
  - If frames!=0 and the new count equals frames, go to DONE.
  - Otherwise compute nxt = hi_len + hi_step in CNT_W+1 bits.
  - If nxt > eff_max, hi_len = max(hi_init,1); else hi_len = nxt. Then go to HIGH.
  - eff_max = max(hi_max, hi_init).
- DONE: one cycle with o_done=1, o_seq_valid=0, o_busy=0, o_frame_cnt held; next state IDLE. o_frame_cnt holds its value until the next accept.
- Free-running (frames=0): o_frame_cnt wraps modulo 2^FRM_W; it never completes.
- i_hold (in HIGH or LOW):
  - State, run counter and hi_len freeze; o_seq holds its last value; o_seq_valid=0.
  - Resume continues the same run with no lost or repeated bit.
  - i_hold is ignored in IDLE and DONE.
- i_stop:
  - In HIGH, LOW or DONE: next cycle is IDLE with o_seq=0 and no o_done pulse.
  - If asserted in DONE, the o_done already registered for that cycle still completes; no extra pulse.
  - Has priority over i_hold.
  - Ignored in IDLE, and it blocks a simultaneous config accept (o_cfg_ready is gated by !i_stop).
- i_cfg_valid outside IDLE is ignored; the config is not queued.
- Reset mid-operation: immediate return to the reset values; the captured config is discarded.

Decomposition:
- Package seq_pkg:
  - state encoding localparams ST_IDLE/ST_HIGH/ST_LOW/ST_DONE (2 bits)
  - default CNT_W/FRM_W
  - helper function for the saturating/wrapping next-length computation
- One sub-module, seq_run_cnt: CNT_W down-counter with load, hold and a "last" flag. seq_sched instantiates it for the run timing.

Test Plan:
1. Basic: init=1, step=1, max=3, lo=1, frames=4.
   - o_seq = 1,0,1,1,0,1,1,1,0,1,0 with o_seq_valid high on all 11 cycles.
   - o_done pulses on the next cycle; o_frame_cnt=4.
2. Zero handling: init=0, step=0, lo=0, frames=3.
   - o_seq = 1,0,1,0,1,0, then o_done.
   - o_cfg_ready returns to 1 the cycle after DONE.
3. Hold: basic config with i_hold high for 3 cycles during the second cycle of the 2nd high run.
   - o_seq_valid=0 and o_seq=1 during the hold.
   - The pattern resumes with exactly one more 1 before the 0.
4. Stop: assert i_stop during frame 2 LOW.
   - Next cycle: IDLE, o_busy=0, o_seq=0, no o_done.
   - A new config is accepted on the following cycle.
5. Free-run wrap: init=2, step=3, max=6, frames=0.
   - High runs are 2,5,2,5,...
   - o_frame_cnt wraps 255→0 without o_done.
6. Async reset mid-HIGH: all outputs return to their reset values immediately; o_cfg_ready=1 after release.
